// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the four-requester bus arbiter.
// Holds the FSM state enum and the requester count.
package bus_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between the four bus masters and the arbiter.
// The arbiter takes the slave view; the requester side takes the master view.
interface bus_arbiter4_if;
    import bus_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] oe;
    logic [1:0]         sel;
    logic               busy;

    modport master (
        output req,
        input  gnt, oe, sel, busy
    );

    modport slave (
        input  req,
        output gnt, oe, sel, busy
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request after last_owner,
// wrapping so that last_owner itself is considered last.
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_owner,
    output logic               valid,
    output logic [1:0]         idx
);

    always_comb begin
        valid = 1'b0;
        idx   = last_owner;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[last_owner + 2'(i)]) begin
                valid = 1'b1;
                idx   = last_owner + 2'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with burst limit and turnaround gap.
// Define BUS_ARB_LOCK_EN to add a lock input that suppresses forced release.
module bus_arbiter4
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST   = 8,
    parameter int TURN_CYCLES = 1
) (
    input logic           clock,
    input logic           reset_n,
`ifdef BUS_ARB_LOCK_EN
    input logic           lock,
`endif
    bus_arbiter4_if.slave bus
);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] oe_q, oe_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [7:0]         burst_q, burst_d;
    logic [1:0]         turn_q, turn_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       force_ok;
    logic       others;
    logic       rel;
    logic       turn_last;
    logic       arb;

`ifdef BUS_ARB_LOCK_EN
    assign force_ok = !lock;
`else
    assign force_ok = 1'b1;
`endif

    rr_pick4 u_pick (
        .req        (bus.req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign others    = |(bus.req & ~gnt_q);
    assign rel       = !bus.req[sel_q] ||
                       (burst_q >= 8'(MAX_BURST) && others && force_ok);
    assign turn_last = (turn_q == 2'(TURN_CYCLES - 1));
    assign arb       = (state_q == IDLE) ||
                       (state_q == TURN && turn_last);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        oe_d    = oe_q;
        sel_d   = sel_q;
        last_d  = last_q;
        burst_d = burst_q;
        turn_d  = turn_q;
        unique case (state_q)
            IDLE: ;
            GRANT: begin
                if (burst_q < 8'(MAX_BURST))
                    burst_d = burst_q + 8'd1;
                if (rel) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    oe_d    = '0;
                    last_d  = sel_q;
                    burst_d = '0;
                    turn_d  = '0;
                end
            end
            TURN: begin
                if (turn_last)
                    state_d = IDLE;
                else
                    turn_d = turn_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        // Requests are only looked at from IDLE or the last TURN cycle.
        if (arb && pick_valid) begin
            state_d = GRANT;
            gnt_d   = onehot(pick_idx);
            oe_d    = onehot(pick_idx);
            sel_d   = pick_idx;
            burst_d = 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            oe_q    <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            burst_q <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.oe   = oe_q;
    assign bus.sel  = sel_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, meaning max grant cycles before forced rotation when others wait (legal 2..255).
REQ-002 SHALL have parameter TURN_CYCLES, default 1, meaning idle cycles with all oe low between owners (legal 1..3).
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  per-requester bus request, level.
REQ-006 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-007 SHALL have port oe  output  4  one-hot enables for the four 64-bit tri-state bus drivers, registered.
REQ-008 SHALL have port sel  output  2  binary index of current/last owner, for the 4:1 read-back mux.
REQ-009 SHALL have port busy  output  1  high while any grant is held or a turnaround is in progress.

Function
REQ-010 SHALL implement states IDLE, GRANT, TURN.
REQ-011 IDLE: gnt=0, oe=0; if any req bit is set at a clock edge, the next state SHALL be GRANT, with the winner's gnt/oe bit high from that edge (1-cycle latency).
REQ-012 The winner SHALL be chosen round-robin: search starts at last_owner+1 mod 4 and takes the first set req bit.
REQ-013 GRANT: gnt=oe=one-hot owner, sel=owner index; burst_cnt SHALL increment each cycle and saturate at MAX_BURST.
REQ-014 GRANT SHALL release when req[owner]=0, or when burst_cnt>=MAX_BURST and any other req bit is set; release clears gnt/oe at the next edge, sets last_owner=owner, and enters TURN.
REQ-015 With burst_cnt at MAX_BURST and no other requester, the owner SHALL keep the grant indefinitely.
REQ-016 TURN SHALL last exactly TURN_CYCLES cycles with gnt=oe=0, then re-arbitrate as in IDLE (direct to GRANT if any req, else IDLE).
REQ-017 Arbitration out of TURN SHALL include the previous owner, at lowest priority.
REQ-018 oe SHALL never have more than one bit set, and SHALL never change directly from one nonzero value to a different nonzero value.
REQ-019 sel SHALL hold the last owner's index while in IDLE or TURN.
REQ-020 busy SHALL equal (state != IDLE).
REQ-021 Requests arriving or dropping during TURN SHALL only be sampled on its final cycle.

Reset
REQ-022 reset_n low SHALL immediately force: state=IDLE, gnt=0, oe=0, sel=0, busy=0, burst_cnt=0, last_owner=3 (requester 0 first priority).
REQ-023 Reset asserted mid-GRANT or mid-TURN SHALL drop oe in the same cycle, with no waiting for a clock edge.

Configuration
REQ-024 Macro BUS_ARB_LOCK_EN, when defined, SHALL add port lock (input, 1): while lock=1 in GRANT, the MAX_BURST forced release is suppressed; only req[owner]=0 releases.
REQ-025 Without BUS_ARB_LOCK_EN, no lock port SHALL exist and forced release SHALL always apply.

Structure
REQ-026 Package bus_arb_pkg SHALL hold the state enum (IDLE/GRANT/TURN) and constant NUM_REQ=4.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs req, last_owner; outputs valid, idx).

Verification
REQ-028 Reset, then req=4'b0001 at edge 0 -> gnt=oe=0001, sel=0, busy=1 after edge 0.
REQ-029 req=4'b1111 held, MAX_BURST=8, TURN_CYCLES=1 -> grants rotate 0,1,2,3,0 with 8 cycles each and a 1-cycle oe=0 gap between owners.
REQ-030 Owner 2 holds req alone for 20 cycles -> gnt stays 0100 throughout; req[2] drops -> 1 TURN cycle, then IDLE, sel=2.
REQ-031 reset_n pulsed low mid-GRANT between clock edges -> oe=0 immediately; after release, req=4'b1000 -> grant 3 is issued after 1 cycle.
REQ-032 With BUS_ARB_LOCK_EN, lock=1, req=4'b0011, owner 0 -> owner 0 keeps the grant past 8 cycles; lock=0 -> release at the next edge, TURN, then gnt=0010.
REQ-033 Every scenario SHALL assert that oe is never multi-hot and never switches between owners without a gap.
